// File: rtl/datamover_rd_checker.sv
// MM2S read-back checker: consumes the read stream, compares each beat against
// the incrementing seed pattern and reports pass/fail, error count, first error and flags.
module datamover_rd_checker #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned LENGTH_WIDTH   = 9,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [LENGTH_WIDTH-1:0]   i_length,
  input  logic [DATA_WIDTH-1:0]     i_seed,
  input  logic [DATA_WIDTH-1:0]     i_mm2s_rd_tdata,
  input  logic [DATA_WIDTH/8-1:0]   i_mm2s_rd_tkeep,
  input  logic                      i_mm2s_rd_tvalid,
  input  logic                      i_mm2s_rd_tlast,
  output logic                      o_mm2s_rd_tready,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_pass,
  output logic [15:0]               o_err_count,
  output logic [LENGTH_WIDTH-1:0]   o_first_err_idx,
  output logic [DATA_WIDTH-1:0]     o_first_err_data,
  output logic [4:0]                o_err_flags
);

  localparam int unsigned TMO_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned FLAG_DATA  = 0;
  localparam int unsigned FLAG_EARLY = 1;
  localparam int unsigned FLAG_MISS  = 2;
  localparam int unsigned FLAG_TMO   = 3;
  localparam int unsigned FLAG_ZERO  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [LENGTH_WIDTH-1:0]   len_q, len_d;
  logic [LENGTH_WIDTH-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]     exp_q, exp_d;
  logic [TMO_WIDTH-1:0]      tmo_q, tmo_d;
  logic [15:0]               err_cnt_q, err_cnt_d;
  logic [LENGTH_WIDTH-1:0]   first_idx_q, first_idx_d;
  logic [DATA_WIDTH-1:0]     first_data_q, first_data_d;
  logic [4:0]                flags_q, flags_d;
  logic                      pass_q, pass_d;
  logic                      done_q, done_d;

  logic accept;
  logic beat_bad;
  logic last_idx;
  logic finish;

  assign accept   = (state_q == ST_RUN) && i_mm2s_rd_tvalid;
  assign beat_bad = (i_mm2s_rd_tdata != exp_q) || (i_mm2s_rd_tkeep != '1);
  assign last_idx = (idx_q == (len_q - LENGTH_WIDTH'(1)));

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    exp_d        = exp_q;
    tmo_d        = tmo_q;
    err_cnt_d    = err_cnt_q;
    first_idx_d  = first_idx_q;
    first_data_d = first_data_q;
    flags_d      = flags_q;
    pass_d       = pass_q;
    done_d       = 1'b0;
    finish       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          err_cnt_d    = '0;
          first_idx_d  = '0;
          first_data_d = '0;
          flags_d      = '0;
          pass_d       = 1'b0;
          if (i_length == '0) begin
            flags_d[FLAG_ZERO] = 1'b1;
            done_d             = 1'b1;
          end else begin
            state_d = ST_RUN;
            len_d   = i_length;
            idx_d   = '0;
            exp_d   = i_seed;  // running expected word stands in for seed + k
            tmo_d   = '0;
          end
        end
      end

      ST_RUN: begin
        if (accept) begin
          tmo_d = '0;
          idx_d = idx_q + LENGTH_WIDTH'(1);
          exp_d = exp_q + DATA_WIDTH'(1);
          if (beat_bad) begin
            if (!flags_q[FLAG_DATA]) begin
              first_idx_d  = idx_q;
              first_data_d = i_mm2s_rd_tdata;
            end
            flags_d[FLAG_DATA] = 1'b1;
            if (err_cnt_q != 16'hFFFF) begin
              err_cnt_d = err_cnt_q + 16'd1;
            end
          end
          if (last_idx) begin
            if (!i_mm2s_rd_tlast) begin
              flags_d[FLAG_MISS] = 1'b1;
            end
            finish = 1'b1;
          end else if (i_mm2s_rd_tlast) begin
            flags_d[FLAG_EARLY] = 1'b1;
            finish              = 1'b1;
          end
        end else if (tmo_q == TMO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          flags_d[FLAG_TMO] = 1'b1;
          finish            = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_WIDTH'(1);
        end
      end
    endcase

    if (finish) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
      pass_d  = (flags_d == '0) && (err_cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      exp_q        <= '0;
      tmo_q        <= '0;
      err_cnt_q    <= '0;
      first_idx_q  <= '0;
      first_data_q <= '0;
      flags_q      <= '0;
      pass_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      exp_q        <= exp_d;
      tmo_q        <= tmo_d;
      err_cnt_q    <= err_cnt_d;
      first_idx_q  <= first_idx_d;
      first_data_q <= first_data_d;
      flags_q      <= flags_d;
      pass_q       <= pass_d;
      done_q       <= done_d;
    end
  end

  assign o_mm2s_rd_tready = (state_q == ST_RUN);
  assign o_busy           = (state_q == ST_RUN);
  assign o_done           = done_q;
  assign o_pass           = pass_q;
  assign o_err_count      = err_cnt_q;
  assign o_first_err_idx  = first_idx_q;
  assign o_first_err_data = first_data_q;
  assign o_err_flags      = flags_q;

endmodule
